// File: rtl/router_switch_ctrl.sv
// Two-input wormhole switch for one ring router node.
// Ring and local NI sources share a single registered output slot.
// Each packet is steered once, at its head, to the forward or eject port.
module router_switch_ctrl #(
    parameter int FLIT_W     = 8,
    parameter int NODE_W     = 2,
    parameter logic [FLIT_W-NODE_W-1:0] HEAD_TAG = 6'b101111,
    parameter logic [FLIT_W-NODE_W-1:0] TAIL_TAG = 6'b110000,
    parameter int MAX_LEN    = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] current_node,
    input  logic [FLIT_W-1:0] ring_flit,
    input  logic              ring_valid,
    output logic              ring_ready,
    input  logic [FLIT_W-1:0] ni_flit,
    input  logic              ni_valid,
    output logic              ni_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    output logic              ej_valid,
    input  logic              ej_ready,
    output logic              err_orphan,
    output logic              err_len
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int ST_W  = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, RING_PKT, NI_PKT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ST_W-1:0]   starve_cnt, starve_nx;
    logic              to_ej, to_ej_nx;
    logic [FLIT_W-1:0] out_nx;
    logic              fwd_nx, ej_nx;

    logic ring_head, ring_tail, ni_head, ni_tail;
    logic slot_free;
    logic ring_pick, ni_pick;
    logic pkt_acc, pkt_tail;
    logic [FLIT_W-1:0] pkt_flit;

    assign ring_head = (ring_flit[FLIT_W-1:NODE_W] == HEAD_TAG);
    assign ring_tail = (ring_flit[FLIT_W-1:NODE_W] == TAIL_TAG);
    assign ni_head   = (ni_flit[FLIT_W-1:NODE_W] == HEAD_TAG);
    assign ni_tail   = (ni_flit[FLIT_W-1:NODE_W] == TAIL_TAG);

    // The slot can take a new flit if it is empty or its current flit leaves this cycle
    assign slot_free = !((fwd_valid && !fwd_ready) || (ej_valid && !ej_ready));

    // Arbitration, handshakes, packet tracking and next output register contents
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        starve_nx  = starve_cnt;
        to_ej_nx   = to_ej;
        out_nx     = out_flit;
        fwd_nx     = fwd_valid && !fwd_ready;
        ej_nx      = ej_valid && !ej_ready;
        ring_ready = 1'b0;
        ni_ready   = 1'b0;
        err_orphan = 1'b0;
        err_len    = 1'b0;
        ring_pick  = 1'b0;
        ni_pick    = 1'b0;
        pkt_acc    = 1'b0;
        pkt_tail   = 1'b0;
        pkt_flit   = '0;

        case (state)
            IDLE: begin
                if (ring_valid && !ring_head) begin
                    ring_ready = 1'b1;
                    err_orphan = 1'b1;
                end
                if (ni_valid && !ni_head) begin
                    ni_ready   = 1'b1;
                    err_orphan = 1'b1;
                end
                ring_pick = ring_valid && ring_head &&
                            !(ni_valid && ni_head && starve_cnt == ST_W'(STARVE_LIM));
                ni_pick   = ni_valid && ni_head && !ring_pick;
                if (ring_pick) begin
                    ring_ready = slot_free;
                    if (slot_free) begin
                        state_nx = RING_PKT;
                        cnt_nx   = CNT_W'(1);
                        to_ej_nx = (ring_flit[NODE_W-1:0] == current_node);
                        out_nx   = ring_flit;
                        fwd_nx   = (ring_flit[NODE_W-1:0] != current_node);
                        ej_nx    = (ring_flit[NODE_W-1:0] == current_node);
                        if (ni_valid && ni_head && starve_cnt != ST_W'(STARVE_LIM))
                            starve_nx = starve_cnt + 1'b1;
                    end
                end else if (ni_pick) begin
                    ni_ready = slot_free;
                    if (slot_free) begin
                        state_nx  = NI_PKT;
                        cnt_nx    = CNT_W'(1);
                        to_ej_nx  = (ni_flit[NODE_W-1:0] == current_node);
                        out_nx    = ni_flit;
                        fwd_nx    = (ni_flit[NODE_W-1:0] != current_node);
                        ej_nx     = (ni_flit[NODE_W-1:0] == current_node);
                        starve_nx = '0;
                    end
                end
            end
            RING_PKT: begin
                ring_ready = slot_free;
                pkt_acc    = ring_valid && slot_free;
                pkt_flit   = ring_flit;
                pkt_tail   = ring_tail;
            end
            NI_PKT: begin
                ni_ready = slot_free;
                pkt_acc  = ni_valid && slot_free;
                pkt_flit = ni_flit;
                pkt_tail = ni_tail;
            end
            default: state_nx = IDLE;
        endcase

        if (pkt_acc) begin
            out_nx = pkt_flit;
            fwd_nx = !to_ej;
            ej_nx  = to_ej;
            if (pkt_tail || cnt == CNT_W'(MAX_LEN - 1)) begin
                state_nx = IDLE;
                cnt_nx   = '0;
                err_len  = !pkt_tail;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end

        if (rst) begin
            ring_ready = 1'b0;
            ni_ready   = 1'b0;
            err_orphan = 1'b0;
            err_len    = 1'b0;
        end
    end

    // State, counters and the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            to_ej      <= 1'b0;
            out_flit   <= '0;
            fwd_valid  <= 1'b0;
            ej_valid   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            starve_cnt <= starve_nx;
            to_ej      <= to_ej_nx;
            out_flit   <= out_nx;
            fwd_valid  <= fwd_nx;
            ej_valid   <= ej_nx;
        end
    end

endmodule

// File: tb/tb_router_switch_ctrl.sv
// Self-checking bench for router_switch_ctrl: directed packets, a per-cycle
// packet-level reference model and hand-computed literal expectations.
module tb_router_switch_ctrl;

    localparam int MAX_LEN    = 16;
    localparam int STARVE_LIM = 4;
    localparam logic [5:0] HEAD = 6'b101111;
    localparam logic [5:0] TAIL = 6'b110000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] current_node;
    logic [7:0] ring_flit, ni_flit, out_flit;
    logic       ring_valid, ring_ready, ni_valid, ni_ready;
    logic       fwd_valid, fwd_ready, ej_valid, ej_ready;
    logic       err_orphan, err_len;

    int checks = 0;
    int errors = 0;

    router_switch_ctrl dut (
        .clk(clk), .rst(rst), .current_node(current_node),
        .ring_flit(ring_flit), .ring_valid(ring_valid), .ring_ready(ring_ready),
        .ni_flit(ni_flit), .ni_valid(ni_valid), .ni_ready(ni_ready),
        .out_flit(out_flit), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .ej_valid(ej_valid), .ej_ready(ej_ready),
        .err_orphan(err_orphan), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [7:0] rf, input logic nv,
                                 input logic [7:0] nf, input logic fr, input logic er);
        @(posedge clk);
        #1;
        ring_valid = rv; ring_flit = rf;
        ni_valid   = nv; ni_flit   = nf;
        fwd_ready  = fr; ej_ready  = er;
        #1;
    endtask

    function automatic logic is_head(input logic [7:0] f);
        return f[7:2] == HEAD;
    endfunction

    function automatic logic is_tail(input logic [7:0] f);
        return f[7:2] == TAIL;
    endfunction

    // Packet-level reference: who owns the switch, how long the packet is, what sits in the slot
    int         m_owner = 0, m_len = 0, m_starve = 0;
    bit         m_to_ej = 0, m_fv = 0, m_ev = 0;
    logic [7:0] m_out = 8'h00;
    int         n_owner = 0, n_len = 0, n_starve = 0;
    bit         n_to_ej = 0, n_fv = 0, n_ev = 0;
    logic [7:0] n_out = 8'h00;

    // Compare every output against the model mid-cycle and work out the model's next state
    always @(negedge clk) begin
        bit busy, acc, tail, r_pick, n_pick, l_to_ej;
        bit e_rr, e_nr, e_eo, e_el;
        int l_owner, l_len, l_starve;
        logic [7:0] fl;
        if (rst) begin
            checkOutput("model rst out_flit", out_flit, 0);
            checkOutput("model rst fwd_valid", fwd_valid, 0);
            checkOutput("model rst ej_valid", ej_valid, 0);
            checkOutput("model rst ring_ready", ring_ready, 0);
            checkOutput("model rst ni_ready", ni_ready, 0);
            checkOutput("model rst err_orphan", err_orphan, 0);
            checkOutput("model rst err_len", err_len, 0);
            n_owner <= 0; n_len <= 0; n_starve <= 0; n_to_ej <= 0;
            n_fv <= 0; n_ev <= 0; n_out <= 8'h00;
        end else begin
            busy = (m_fv && !fwd_ready) || (m_ev && !ej_ready);
            acc = 0; tail = 0; fl = 8'h00; r_pick = 0; n_pick = 0;
            e_rr = 0; e_nr = 0; e_eo = 0; e_el = 0;
            l_owner = m_owner; l_len = m_len; l_starve = m_starve; l_to_ej = m_to_ej;
            if (m_owner == 0) begin
                if (ring_valid && !is_head(ring_flit)) begin e_rr = 1; e_eo = 1; end
                if (ni_valid && !is_head(ni_flit)) begin e_nr = 1; e_eo = 1; end
                r_pick = ring_valid && is_head(ring_flit) &&
                         !(ni_valid && is_head(ni_flit) && m_starve == STARVE_LIM);
                n_pick = ni_valid && is_head(ni_flit) && !r_pick;
                if (r_pick) begin
                    e_rr = !busy;
                    if (!busy) begin
                        acc = 1; fl = ring_flit; l_owner = 1;
                        if (ni_valid && is_head(ni_flit))
                            l_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
                    end
                end else if (n_pick) begin
                    e_nr = !busy;
                    if (!busy) begin
                        acc = 1; fl = ni_flit; l_owner = 2; l_starve = 0;
                    end
                end
                if (acc) begin
                    l_to_ej = (fl[1:0] == current_node);
                    l_len = 1;
                end
            end else begin
                if (m_owner == 1) begin
                    e_rr = !busy; acc = ring_valid && !busy; fl = ring_flit;
                end else begin
                    e_nr = !busy; acc = ni_valid && !busy; fl = ni_flit;
                end
                if (acc) begin
                    tail = is_tail(fl);
                    if (tail || m_len + 1 == MAX_LEN) begin
                        l_owner = 0; l_len = 0; e_el = !tail;
                    end else begin
                        l_len = m_len + 1;
                    end
                end
            end
            checkOutput("model out_flit", out_flit, m_out);
            checkOutput("model fwd_valid", fwd_valid, m_fv);
            checkOutput("model ej_valid", ej_valid, m_ev);
            checkOutput("model ring_ready", ring_ready, e_rr);
            checkOutput("model ni_ready", ni_ready, e_nr);
            checkOutput("model err_orphan", err_orphan, e_eo);
            checkOutput("model err_len", err_len, e_el);
            n_owner <= l_owner; n_len <= l_len; n_starve <= l_starve; n_to_ej <= l_to_ej;
            if (acc) begin
                n_out <= fl; n_fv <= !l_to_ej; n_ev <= l_to_ej;
            end else begin
                n_out <= m_out; n_fv <= m_fv && !fwd_ready; n_ev <= m_ev && !ej_ready;
            end
        end
    end

    // Advance the model on each clock edge; reset clears it at once
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 0; m_len <= 0; m_starve <= 0; m_to_ej <= 0;
            m_fv <= 0; m_ev <= 0; m_out <= 8'h00;
        end else begin
            m_owner <= n_owner; m_len <= n_len; m_starve <= n_starve; m_to_ej <= n_to_ej;
            m_fv <= n_fv; m_ev <= n_ev; m_out <= n_out;
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with literal expectations
    initial begin
        logic [7:0] ring_q[10];
        logic [7:0] ni_q[3];
        int grants[$];
        int ri, nidx;
        int exp_grant[6];

        current_node = 2'd2;
        ring_valid = 1; ring_flit = 8'h15;
        ni_valid = 0; ni_flit = 8'h00;
        fwd_ready = 0; ej_ready = 0;

        // Reset state, with an orphan presented that must not be accepted
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_flit", out_flit, 0);
        checkOutput("reset fwd_valid", fwd_valid, 0);
        checkOutput("reset ej_valid", ej_valid, 0);
        checkOutput("reset ring_ready", ring_ready, 0);
        checkOutput("reset err_orphan", err_orphan, 0);

        // Ejected ring packet, first head offered right at reset release
        rst = 0; ring_valid = 1; ring_flit = 8'hBE; fwd_ready = 1; ej_ready = 1;
        #1;
        checkOutput("eject head ring_ready", ring_ready, 1);
        applyStimulus(1, 8'h15, 0, 8'h00, 1, 1);
        checkOutput("eject out head", out_flit, 8'hBE);
        checkOutput("eject ej_valid 1", ej_valid, 1);
        checkOutput("eject fwd_valid 1", fwd_valid, 0);
        applyStimulus(1, 8'hC1, 0, 8'h00, 1, 1);
        checkOutput("eject out body", out_flit, 8'h15);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        checkOutput("eject out tail", out_flit, 8'hC1);
        checkOutput("eject ej_valid 3", ej_valid, 1);
        checkOutput("eject fwd_valid 3", fwd_valid, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        checkOutput("eject drained", ej_valid, 0);

        // Forwarded packet held by downstream backpressure for three cycles
        applyStimulus(1, 8'hBD, 0, 8'h00, 0, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 8'h22, 0, 8'h00, 0, 1);
            checkOutput("stall fwd_valid", fwd_valid, 1);
            checkOutput("stall out_flit", out_flit, 8'hBD);
            checkOutput("stall ring_ready", ring_ready, 0);
        end
        applyStimulus(1, 8'h22, 0, 8'h00, 1, 1);
        checkOutput("unstall ring_ready", ring_ready, 1);
        applyStimulus(1, 8'hC0, 0, 8'h00, 1, 1);
        checkOutput("unstall out body", out_flit, 8'h22);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        checkOutput("unstall out tail", out_flit, 8'hC0);
        checkOutput("unstall fwd_valid", fwd_valid, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);

        // Starvation: ring and NI heads both waiting continuously
        for (int k = 0; k < 5; k++) begin
            ring_q[2*k] = 8'hBD; ring_q[2*k+1] = 8'hC1;
        end
        ni_q[0] = 8'hBC; ni_q[1] = 8'h33; ni_q[2] = 8'hC0;
        ri = 0; nidx = 0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(ri < 10, (ri < 10) ? ring_q[ri] : 8'h00,
                          nidx < 3, (nidx < 3) ? ni_q[nidx] : 8'h00, 1, 1);
            if (ring_valid && ring_ready) begin
                if (is_head(ring_flit)) grants.push_back(1);
                ri++;
            end
            if (ni_valid && ni_ready) begin
                if (is_head(ni_flit)) grants.push_back(2);
                nidx++;
            end
        end
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        exp_grant = '{1, 1, 1, 1, 2, 1};
        checkOutput("starve grant count", grants.size(), 6);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("starve grant %0d", k),
                        (k < grants.size()) ? grants[k] : -1, exp_grant[k]);

        // Over-long packet: closed at the 16th flit, 17th dropped as an orphan
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, (i == 0) ? 8'hBD : 8'(8'h05 + i), 0, 8'h00, 1, 1);
            if (i == 14) checkOutput("maxlen err_len early", err_len, 0);
            if (i == 15) checkOutput("maxlen err_len", err_len, 1);
            if (i == 16) begin
                checkOutput("maxlen orphan", err_orphan, 1);
                checkOutput("maxlen orphan ready", ring_ready, 1);
                checkOutput("maxlen last out", out_flit, 8'h14);
            end
        end
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        checkOutput("maxlen drop no output", fwd_valid, 0);

        // NI loopback ejection while a ring head waits
        applyStimulus(0, 8'h00, 1, 8'hBE, 1, 1);
        checkOutput("loop ni_ready", ni_ready, 1);
        applyStimulus(1, 8'hBD, 1, 8'h44, 1, 1);
        checkOutput("loop out head", out_flit, 8'hBE);
        checkOutput("loop ej_valid", ej_valid, 1);
        checkOutput("loop ring waits", ring_ready, 0);
        applyStimulus(1, 8'hBD, 1, 8'hC2, 1, 1);
        checkOutput("loop out body", out_flit, 8'h44);
        checkOutput("loop ring waits 2", ring_ready, 0);
        applyStimulus(1, 8'hBD, 0, 8'h00, 1, 1);
        checkOutput("loop ring granted", ring_ready, 1);
        checkOutput("loop out tail", out_flit, 8'hC2);
        applyStimulus(1, 8'hC3, 0, 8'h00, 1, 1);
        checkOutput("loop ring fwd", fwd_valid, 1);
        checkOutput("loop ring out", out_flit, 8'hBD);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);

        // Reset in the middle of a packet
        applyStimulus(1, 8'hBD, 0, 8'h00, 1, 1);
        applyStimulus(1, 8'h11, 0, 8'h00, 1, 1);
        applyStimulus(1, 8'h12, 0, 8'h00, 1, 1);
        checkOutput("midrst out before", out_flit, 8'h11);
        rst = 1;
        #1;
        checkOutput("midrst out_flit", out_flit, 0);
        checkOutput("midrst fwd_valid", fwd_valid, 0);
        checkOutput("midrst ring_ready", ring_ready, 0);
        ring_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        applyStimulus(1, 8'h13, 0, 8'h00, 1, 1);
        checkOutput("midrst orphan", err_orphan, 1);
        checkOutput("midrst orphan ready", ring_ready, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        checkOutput("midrst no output", fwd_valid, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_switch_ctrl.md
ROUTER_SWITCH_CTRL -- requirements
Module: router_switch_ctrl

Interface
REQ-001 Parameter FLIT_W, 8, flit width in bits.
REQ-002 Parameter NODE_W, 2, destination/node-ID width; occupies flit[NODE_W-1:0] of a head flit.
REQ-003 Parameter HEAD_TAG, 6'b101111, head marker in flit[FLIT_W-1:NODE_W].
REQ-004 Parameter TAIL_TAG, 6'b110000, tail marker in flit[FLIT_W-1:NODE_W].
REQ-005 Parameter MAX_LEN, 16, maximum flits per packet including head.
REQ-006 Parameter STARVE_LIM, 4, consecutive ring grants before NI is forced priority.
REQ-007 Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- current_node  in  NODE_W  this router's ID
- ring_flit / ring_valid  in  FLIT_W / 1  upstream ring input
- ring_ready  out  1  ring flit accepted when ring_valid && ring_ready
- ni_flit / ni_valid  in  FLIT_W / 1  local NI injection input
- ni_ready  out  1  NI flit accepted when ni_valid && ni_ready
- out_flit  out  FLIT_W  registered output flit
- fwd_valid / fwd_ready  out / in  1 / 1  downstream ring output
- ej_valid / ej_ready  out / in  1 / 1  local ejection output
- err_orphan  out  1  one-cycle pulse: non-head flit dropped in IDLE
- err_len  out  1  one-cycle pulse: packet force-closed at MAX_LEN

Function
REQ-010 FSM states IDLE, RING_PKT, NI_PKT; wormhole: a granted packet owns the switch until closed.
REQ-011 Head flit: flit[FLIT_W-1:NODE_W]==HEAD_TAG; tail: ==TAIL_TAG; anything else is body.
REQ-012 Port select latched at head: dest==current_node -> eject, else forward; applies to both sources (NI to own node = loopback eject).
REQ-013 Single output register; out_flit valid on exactly one of fwd_valid/ej_valid; drains on valid&&ready.
REQ-014 Output slot free = selected valid low, or selected valid&&ready this cycle.
REQ-015 IDLE arbitration, same cycle: ring head wins over NI head, unless starve_cnt==STARVE_LIM, then NI wins.
REQ-016 starve_cnt: +1 (saturating at STARVE_LIM) on ring grant while NI presents a head; cleared on NI grant.
REQ-017 Granted source ready=1 only when output slot free for its target port; other source ready=0.
REQ-018 Accepted flit appears on out_flit with selected valid the next cycle (latency 1, throughput 1 flit/cycle).
REQ-019 Ring non-head flit with ring_valid in IDLE: accepted (ring_ready=1), dropped, err_orphan pulses; NI non-head in IDLE likewise.
REQ-020 Flit counter: 1 at head, +1 per accepted flit; packet closes on accepted tail or when count reaches MAX_LEN.
REQ-021 Close by MAX_LEN without tail: err_len pulses same cycle as the MAX_LEN-th acceptance; FSM to IDLE.
REQ-022 Head+tail cannot coincide; single-flit packets not supported; a head inside a packet is forwarded as body.
REQ-023 Closing acceptance returns FSM to IDLE next cycle; new arbitration starts that cycle.
REQ-024 Backpressure mid-packet: no acceptance, no state/counter change while slot busy.

Reset
REQ-030 rst high: state IDLE, counters 0, out_flit 0, fwd_valid/ej_valid/ring_ready/ni_ready/err_orphan/err_len 0.
REQ-031 Reset mid-packet discards the packet and output register; after release, next flit needs a head.
REQ-032 First arbitration possible in the first clk edge after rst deasserts.

Verification
REQ-040 current_node=2, ring head 0xBE (dest 2), body, tail 0xC1, ej_ready=1 -> three flits on ej_valid, one per cycle, 1-cycle latency; fwd_valid stays 0.
REQ-041 Ring head 0xBD (dest 1) with fwd_ready=0 for 3 cycles -> fwd_valid held, out_flit stable, ring_ready=0 until drained.
REQ-042 Ring and NI heads both valid continuously, STARVE_LIM=4 -> 4 ring packets granted, 5th grant to NI, starve_cnt cleared.
REQ-043 17 ring flits with no tail, MAX_LEN=16 -> err_len pulse on 16th, FSM IDLE, 17th dropped with err_orphan.
REQ-044 NI head dest==current_node -> loopback on ej_valid; ring head arriving meanwhile waits with ring_ready=0.
REQ-045 rst asserted after 2nd flit of a packet -> all outputs 0 immediately; body flit after release -> err_orphan.
